bp_cce_lce_req_ingress: RTL and testbench
=========================================

// Module: bp_cce_lce_req_ingress
// PURPOSE
//  CCE-side receiver for BedRock LCE request messages arriving from the coherence NoC.
//  - Buffers incoming requests in a 2-entry FIFO and decodes each one.
//  - Checks that cached requests are legal.
//  - Issues decoded requests to the CCE engine under a valid->yumi handshake.
//  - Serializes cached (rd/wr) transactions: only one cached transaction is in flight until the engine signals completion.
// PARAMETERS
//  bp_params_p      e_bp_default_cfg  processor config; supplies paddr_width_p, lce_id_width_p, cce_id_width_p, lce_assoc_p, cce_block_width_p
//  block_width_p    cce_block_width_p cached block size in bits; legal cached size = block_width_p/8 bytes
//  err_cnt_width_p  8                 width of the saturating illegal-request counter
// PORTS
//  clk_i              in   1     clock, all flops rising edge
//  reset_n_i          in   1     asynchronous, active-low reset
//  cce_id_i           in   cce_id_width_p  this CCE's id; dst_id mismatch is illegal
//  lce_req_i          in   lce_req_msg_width_lp  BedRock LCE request msg (declare_bp_bedrock_lce_if)
//  lce_req_v_i        in   1     request valid (ready->valid: sender asserts valid only when ready_o=1)
//  lce_req_ready_o    out  1     FIFO has a free entry
//  req_o              out  lce_req_msg_width_lp  head request, passed through unmodified
//  req_class_o        out  3     0 cached_rd, 1 cached_wr, 2 uc_rd, 3 uc_wr, 4 amo
//  req_v_o            out  1     head request valid to engine
//  req_yumi_i         in   1     engine consumes head (legal only when req_v_o=1)
//  cached_done_i      in   1     one-cycle pulse: in-flight cached transaction finished
//  err_o              out  1     one-cycle pulse when an illegal request is dropped
//  err_cnt_o          out  err_cnt_width_p  saturating count of dropped requests
//  stats_o            out  5x32  per-class accepted counters (see CONFIGURATION)
// BEHAVIOUR
//  Reset (reset_n_i=0, asynchronous) values:
//  - FIFO empty; lce_req_ready_o=0 during reset, 1 the first cycle after release.
//  - req_v_o=0, err_o=0, err_cnt_o=0, stats_o=0, state=e_idle.
//  FIFO
//  - 2 entries; enq = lce_req_v_i & lce_req_ready_o; deq = req_yumi_i | drop.
//  - lce_req_ready_o = ~full. Simultaneous enq and deq when full is not allowed, since ready_o is already 0.
//  - Enq+deq in the same cycle when 1 entry is held keeps the count at 1.
//  - Write and read pointers are 1 bit each and wrap.
//  Decode (combinational on FIFO head)
//  - e_bedrock_req_rd -> 0, e_bedrock_req_wr -> 1, e_bedrock_req_uc_rd -> 2, e_bedrock_req_uc_wr -> 3, any amo* type -> 4.
//  - A request is illegal when any of these holds:
//    - payload.dst_id != cce_id_i;
//    - class 0/1 with size != block size, or addr not aligned to the block size;
//    - unknown msg_type.
//  - An illegal head is dropped the cycle it reaches the head and is never presented: req_v_o=0 that cycle, err_o=1.
//  - On a drop, err_cnt_o increments and saturates at all-ones.
//  FSM: e_idle, e_cached_busy
//  - e_idle: req_v_o = head valid & legal. A yumi on class 0/1 -> e_cached_busy. A yumi on other classes stays in e_idle.
//  - e_cached_busy: a legal class 0/1 head stalls (req_v_o=0).
//    - A class 2-4 head is presented only if its addr block differs from the latched busy block address; otherwise it stalls.
//    - Head-of-line order is kept: no bypass of a stalled head.
//    - cached_done_i -> e_idle. The head is re-evaluated the following cycle, so req_v_o for a stalled cached head rises 1 cycle after cached_done_i.
//  - cached_done_i while in e_idle is ignored. It is flagged by an assertion in simulation.
//  - Issue latency: a request enqueued at cycle N into an empty FIFO in e_idle gives req_v_o=1 at cycle N+1.
//  - req_o and req_class_o are stable while req_v_o=1 and no yumi has occurred.
// CONFIGURATION
//  BP_CCE_REQ_INGRESS_STATS_EN
//  - Defined: five 32-bit wrapping counters, one per class, increment on each req_yumi_i of that class.
//    stats_o = {amo, uc_wr, uc_rd, cached_wr, cached_rd}.
//  - Undefined: the counters are not built and stats_o is tied to 0.
// TESTING
//  1. Reset mid-stream with 2 entries queued, busy state set -> next cycle FIFO empty, req_v_o=0, err_cnt_o=0, state e_idle.
//  2. Cached rd addr 0x8000_0040 size 64B, yumi; then cached wr 0x8000_0080 -> wr stalls; cached_done_i pulse -> req_v_o=1 one cycle later.
//  3. e_cached_busy on block 0x40: uc_rd 0x8000_0048 stalls; uc_wr 0x8000_1000 queued behind it also waits; done -> both issue in order.
//  4. Cached rd size 8B, or dst_id=cce_id_i+1 -> err_o=1, req_v_o stays 0, err_cnt_o=1; 300 bad requests with err_cnt_width_p=8 -> err_cnt_o=255.
//  5. Back-to-back uc_wr every cycle with req_yumi_i held 1 -> lce_req_ready_o stays 1 and 1 request issues per cycle.
//     Holding req_yumi_i=0 -> ready_o=0 after 2 enqueues.
//  6. STATS_EN defined: 3 cached_rd and 2 amo issued -> stats_o[31:0]=3, stats_o[159:128]=2. Undefined -> stats_o=0.

Source files
------------

// File: rtl/bp_cce_lce_req_ingress.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : bp_cce_lce_req_ingress                                          |
// | Purpose  : CCE-side ingress for BedRock LCE requests. 2-entry FIFO, head   |
// |            decode/legality check, valid->yumi issue to the CCE engine and  |
// |            serialization of cached (rd/wr) transactions.                   |
// | Options  : BP_CCE_REQ_INGRESS_STATS_EN builds five per-class 32-bit        |
// |            accepted-request counters on stats_o (tied to 0 otherwise).     |
// | Msg fmt  : {data, non_exclusive, lru_way_id, src_id, dst_id, addr,         |
// |             size, msg_type}  (LSB first: msg_type[3:0], size[2:0], ...)    |
// |            size code = log2(bytes); msg_type 0 rd, 1 wr, 2 uc_rd,          |
// |            3 uc_wr, 4..7 amo_{swap,add,and,or}, 8..15 unknown.             |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module bp_cce_lce_req_ingress
   #(parameter int paddr_width_p     = 40
   , parameter int lce_id_width_p    = 4
   , parameter int cce_id_width_p    = 4
   , parameter int lce_assoc_p       = 8
   , parameter int cce_block_width_p = 512
   , parameter int block_width_p     = cce_block_width_p
   , parameter int data_width_p      = 64
   , parameter int err_cnt_width_p   = 8
   , localparam int lru_width_lp     = (lce_assoc_p > 1) ? $clog2(lce_assoc_p) : 1
   , localparam int lce_req_msg_width_lp = data_width_p + 1 + lru_width_lp + lce_id_width_p
                                          + cce_id_width_p + paddr_width_p + 3 + 4
   )
   (input  logic                            clk_i
   , input  logic                            reset_n_i
   , input  logic [cce_id_width_p-1:0]       cce_id_i
   , input  logic [lce_req_msg_width_lp-1:0] lce_req_i
   , input  logic                            lce_req_v_i
   , output logic                            lce_req_ready_o
   , output logic [lce_req_msg_width_lp-1:0] req_o
   , output logic [2:0]                      req_class_o
   , output logic                            req_v_o
   , input  logic                            req_yumi_i
   , input  logic                            cached_done_i
   , output logic                            err_o
   , output logic [err_cnt_width_p-1:0]      err_cnt_o
   , output logic [5*32-1:0]                 stats_o
   );

   // Field positions inside a request message
   localparam int c_type_lsb = 0;
   localparam int c_size_lsb = 4;
   localparam int c_addr_lsb = 7;
   localparam int c_dst_lsb  = c_addr_lsb + paddr_width_p;

   // Block geometry: legal cached size code and address offset width
   localparam int          c_blk_off       = $clog2(block_width_p / 8);
   localparam logic [2:0]  c_blk_size_code = 3'(c_blk_off);
   localparam int          c_tag_w         = paddr_width_p - c_blk_off;

   typedef enum logic [0:0] {
      e_idle        = 1'b0,
      e_cached_busy = 1'b1
   } state_e;

   state_e r_state, w_state_nxt;

   logic [lce_req_msg_width_lp-1:0] r_mem [2];
   logic                            r_wptr, r_rptr;
   logic [1:0]                      r_count;
   logic                            r_ready_en;
   logic [c_tag_w-1:0]              r_busy_blk;
   logic [err_cnt_width_p-1:0]      r_err_cnt;

   logic                            w_full, w_head_v, w_enq, w_deq;
   logic [lce_req_msg_width_lp-1:0] w_head;
   logic [3:0]                      w_head_type;
   logic [2:0]                      w_head_size;
   logic [paddr_width_p-1:0]        w_head_addr;
   logic [cce_id_width_p-1:0]       w_head_dst;
   logic [2:0]                      w_class;
   logic                            w_known, w_cached, w_legal, w_blk_differs;
   logic                            w_req_v, w_yumi, w_drop;

   assign w_full          = (r_count == 2'd2);
   assign w_head_v        = (r_count != 2'd0);
   assign lce_req_ready_o = r_ready_en & ~w_full;
   assign w_enq           = lce_req_v_i & lce_req_ready_o;
   assign w_deq           = w_yumi | w_drop;

   assign w_head      = r_mem[r_rptr];
   assign w_head_type = w_head[c_type_lsb +: 4];
   assign w_head_size = w_head[c_size_lsb +: 3];
   assign w_head_addr = w_head[c_addr_lsb +: paddr_width_p];
   assign w_head_dst  = w_head[c_dst_lsb  +: cce_id_width_p];

   // Ready is held low through reset and comes up on the first clock after release
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) r_ready_en <= 1'b0;
      else            r_ready_en <= 1'b1;
   end

   // FIFO storage; contents are don't-care until the count says otherwise
   always_ff @(posedge clk_i) begin
      if (w_enq) r_mem[r_wptr] <= lce_req_i;
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_wptr  <= 1'b0;
         r_rptr  <= 1'b0;
         r_count <= 2'd0;
      end else begin
         if (w_enq) r_wptr <= ~r_wptr;
         if (w_deq) r_rptr <= ~r_rptr;
         case ({w_enq, w_deq})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Head decode: class mapping and legality
   always_comb begin
      w_known = 1'b1;
      w_class = 3'd4;
      case (w_head_type)
         4'd0, 4'd1, 4'd2, 4'd3: w_class = w_head_type[2:0];
         4'd4, 4'd5, 4'd6, 4'd7: w_class = 3'd4;
         default:                w_known = 1'b0;
      endcase
   end

   assign w_cached = w_known & ((w_class == 3'd0) | (w_class == 3'd1));
   assign w_legal  = w_known
                   & (w_head_dst == cce_id_i)
                   & (~w_cached | ((w_head_size == c_blk_size_code)
                                   & (w_head_addr[c_blk_off-1:0] == '0)));
   assign w_blk_differs = (w_head_addr[paddr_width_p-1:c_blk_off] != r_busy_blk);
   assign w_drop        = w_head_v & ~w_legal;

   // Issue control: cached transactions are serialized, uncached only blocked on a block match
   always_comb begin
      w_state_nxt = r_state;
      w_req_v     = 1'b0;
      case (r_state)
         e_idle: begin
            w_req_v = w_head_v & w_legal;
            if (req_yumi_i & w_req_v & w_cached) w_state_nxt = e_cached_busy;
         end
         e_cached_busy: begin
            w_req_v = w_head_v & w_legal & ~w_cached & w_blk_differs;
            if (cached_done_i) w_state_nxt = e_idle;
         end
      endcase
   end

   assign w_yumi = req_yumi_i & w_req_v;

   // State register and block address of the in-flight cached transaction
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_state    <= e_idle;
         r_busy_blk <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_yumi & w_cached) r_busy_blk <= w_head_addr[paddr_width_p-1:c_blk_off];
      end
   end

   // Saturating count of dropped requests
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i)                       r_err_cnt <= '0;
      else if (w_drop && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + err_cnt_width_p'(1);
   end

   assign req_o       = w_head;
   assign req_class_o = w_class;
   assign req_v_o     = w_req_v;
   assign err_o       = w_drop;
   assign err_cnt_o   = r_err_cnt;

`ifdef BP_CCE_REQ_INGRESS_STATS_EN
   for (genvar i = 0; i < 5; i++) begin : g_stats
      logic [31:0] r_cnt;
      // Wrapping per-class count of accepted requests
      always_ff @(posedge clk_i or negedge reset_n_i) begin
         if (!reset_n_i)                         r_cnt <= '0;
         else if (w_yumi && (w_class == 3'(i)))  r_cnt <= r_cnt + 32'd1;
      end
      assign stats_o[32*i +: 32] = r_cnt;
   end
`else
   assign stats_o = '0;
`endif

`ifndef SYNTHESIS
   // A completion with no cached transaction outstanding indicates an engine bug
   a_done_in_idle: assert property (@(posedge clk_i) disable iff (!reset_n_i)
                                    !(cached_done_i && (r_state == e_idle)));
`endif

endmodule
`default_nettype wire

// File: tb/tb_bp_cce_lce_req_ingress.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_bp_cce_lce_req_ingress                                       |
// | Purpose  : Directed self-checking bench for bp_cce_lce_req_ingress.        |
// |            Honours BP_CCE_REQ_INGRESS_STATS_EN for the stats checks.       |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_bp_cce_lce_req_ingress;

   localparam int         c_msg_w = 123;  // 64+1+3+4+4+40+3+4 with default config
   localparam logic [3:0] c_cce   = 4'h3;
   localparam logic [3:0] c_rd = 4'd0, c_wr = 4'd1, c_ucrd = 4'd2, c_ucwr = 4'd3, c_amo = 4'd5;
   localparam logic [2:0] c_sz64 = 3'd6, c_sz8 = 3'd3;

   logic                clk_i = 1'b0;
   logic                reset_n_i = 1'b0;
   logic [3:0]          cce_id_i = c_cce;
   logic [c_msg_w-1:0]  lce_req_i = '0;
   logic                lce_req_v_i = 1'b0;
   logic                lce_req_ready_o;
   logic [c_msg_w-1:0]  req_o;
   logic [2:0]          req_class_o;
   logic                req_v_o;
   logic                req_yumi_i = 1'b0;
   logic                cached_done_i = 1'b0;
   logic                err_o;
   logic [7:0]          err_cnt_o;
   logic [159:0]        stats_o;

   int n_checks = 0;
   int n_errors = 0;

   bp_cce_lce_req_ingress dut (
      .clk_i           (clk_i),
      .reset_n_i       (reset_n_i),
      .cce_id_i        (cce_id_i),
      .lce_req_i       (lce_req_i),
      .lce_req_v_i     (lce_req_v_i),
      .lce_req_ready_o (lce_req_ready_o),
      .req_o           (req_o),
      .req_class_o     (req_class_o),
      .req_v_o         (req_v_o),
      .req_yumi_i      (req_yumi_i),
      .cached_done_i   (cached_done_i),
      .err_o           (err_o),
      .err_cnt_o       (err_cnt_o),
      .stats_o         (stats_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic logic [c_msg_w-1:0] mk(input logic [3:0] t, input logic [2:0] sz,
                                            input logic [39:0] a, input logic [3:0] dst);
      logic [63:0] d;
      d = 64'hA5A5_0000_0000_0000 | {24'h0, a};
      return {d, 1'b0, 3'd2, 4'd1, dst, a, sz, t};
   endfunction

   task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic enq(input logic [c_msg_w-1:0] m);
      chk("ready_before_enq", 160'(lce_req_ready_o), 160'd1);
      lce_req_i   = m;
      lce_req_v_i = 1'b1;
      tick();
      lce_req_v_i = 1'b0;
   endtask

   task automatic yumi();
      req_yumi_i = 1'b1;
      tick();
      req_yumi_i = 1'b0;
   endtask

   task automatic done();
      cached_done_i = 1'b1;
      tick();
      cached_done_i = 1'b0;
   endtask

   logic [c_msg_w-1:0] m_a, m_b, m_c;

   initial begin
      // ---------------- reset state ----------------
      #1;
      chk("rst_ready", 160'(lce_req_ready_o), 160'd0);
      chk("rst_req_v", 160'(req_v_o), 160'd0);
      chk("rst_err",   160'(err_o), 160'd0);
      chk("rst_errcnt", 160'(err_cnt_o), 160'd0);
      chk("rst_stats", stats_o, 160'd0);
      tick();
      #2 reset_n_i = 1'b1;
      tick();
      chk("ready_after_rst", 160'(lce_req_ready_o), 160'd1);

      // ---------------- cached rd then stalled cached wr ----------------
      m_a = mk(c_rd, c_sz64, 40'h00_8000_0040, c_cce);
      enq(m_a);
      chk("rd_latency_v", 160'(req_v_o), 160'd1);
      chk("rd_class", 160'(req_class_o), 160'd0);
      chk("rd_req_o", 160'(req_o), 160'(m_a));
      yumi();
      m_b = mk(c_wr, c_sz64, 40'h00_8000_0080, c_cce);
      enq(m_b);
      chk("wr_stall", 160'(req_v_o), 160'd0);
      tick();
      chk("wr_stall2", 160'(req_v_o), 160'd0);
      cached_done_i = 1'b1;
      #1;
      chk("wr_stall_done_cycle", 160'(req_v_o), 160'd0);
      tick();
      cached_done_i = 1'b0;
      chk("wr_after_done_v", 160'(req_v_o), 160'd1);
      chk("wr_class", 160'(req_class_o), 160'd1);
      chk("wr_req_o", 160'(req_o), 160'(m_b));
      yumi();
      done();

      // ---------------- busy on block 0x40: uncached ordering ----------------
      enq(mk(c_rd, c_sz64, 40'h00_8000_0040, c_cce));
      yumi();
      m_a = mk(c_ucrd, c_sz8, 40'h00_8000_2000, c_cce);
      enq(m_a);
      chk("uc_diff_blk_v", 160'(req_v_o), 160'd1);
      chk("uc_diff_blk_class", 160'(req_class_o), 160'd2);
      yumi();
      m_b = mk(c_ucrd, c_sz8, 40'h00_8000_0048, c_cce);
      m_c = mk(c_ucwr, c_sz8, 40'h00_8000_1000, c_cce);
      enq(m_b);
      chk("uc_same_blk_stall", 160'(req_v_o), 160'd0);
      enq(m_c);
      chk("hol_stall", 160'(req_v_o), 160'd0);
      chk("full_ready", 160'(lce_req_ready_o), 160'd0);
      done();
      chk("hol_first_v", 160'(req_v_o), 160'd1);
      chk("hol_first_req", 160'(req_o), 160'(m_b));
      chk("hol_first_class", 160'(req_class_o), 160'd2);
      yumi();
      chk("hol_second_v", 160'(req_v_o), 160'd1);
      chk("hol_second_req", 160'(req_o), 160'(m_c));
      chk("hol_second_class", 160'(req_class_o), 160'd3);
      yumi();
      chk("hol_empty", 160'(req_v_o), 160'd0);

      // ---------------- illegal requests ----------------
      enq(mk(c_rd, c_sz8, 40'h00_8000_0040, c_cce));
      chk("bad_size_err", 160'(err_o), 160'd1);
      chk("bad_size_v", 160'(req_v_o), 160'd0);
      tick();
      chk("bad_size_cnt", 160'(err_cnt_o), 160'd1);
      chk("bad_size_err_pulse", 160'(err_o), 160'd0);
      chk("bad_size_v_after", 160'(req_v_o), 160'd0);
      enq(mk(c_ucrd, c_sz8, 40'h00_8000_0040, c_cce + 4'd1));
      chk("bad_dst_err", 160'(err_o), 160'd1);
      chk("bad_dst_v", 160'(req_v_o), 160'd0);
      tick();
      chk("bad_dst_cnt", 160'(err_cnt_o), 160'd2);
      enq(mk(c_wr, c_sz64, 40'h00_8000_0044, c_cce));
      chk("misalign_err", 160'(err_o), 160'd1);
      tick();
      enq(mk(4'hF, c_sz8, 40'h00_8000_0040, c_cce));
      chk("unknown_err", 160'(err_o), 160'd1);
      tick();
      chk("four_drops_cnt", 160'(err_cnt_o), 160'd4);
      lce_req_i   = mk(c_rd, c_sz8, 40'h00_8000_0000, c_cce);
      lce_req_v_i = 1'b1;
      for (int i = 0; i < 300; i++) tick();
      lce_req_v_i = 1'b0;
      chk("flood_ready", 160'(lce_req_ready_o), 160'd1);
      tick();
      chk("err_cnt_sat", 160'(err_cnt_o), 160'd255);
      chk("flood_empty", 160'(req_v_o), 160'd0);

      // ---------------- back-to-back uc_wr with yumi held ----------------
      req_yumi_i  = 1'b1;
      m_a         = mk(c_ucwr, c_sz8, 40'h00_9000_0000, c_cce);
      lce_req_i   = m_a;
      lce_req_v_i = 1'b1;
      tick();
      for (int i = 1; i <= 8; i++) begin
         chk("b2b_ready", 160'(lce_req_ready_o), 160'd1);
         chk("b2b_v", 160'(req_v_o), 160'd1);
         chk("b2b_req", 160'(req_o), 160'(m_a));
         m_a       = mk(c_ucwr, c_sz8, 40'h00_9000_0000 + 40'(i * 8), c_cce);
         lce_req_i = m_a;
         tick();
      end
      lce_req_v_i = 1'b0;
      chk("b2b_last_req", 160'(req_o), 160'(m_a));
      tick();
      req_yumi_i = 1'b0;
      chk("b2b_drained", 160'(req_v_o), 160'd0);
      enq(mk(c_ucwr, c_sz8, 40'h00_9000_1000, c_cce));
      chk("one_held_ready", 160'(lce_req_ready_o), 160'd1);
      enq(mk(c_ucwr, c_sz8, 40'h00_9000_2000, c_cce));
      chk("two_held_ready", 160'(lce_req_ready_o), 160'd0);
      yumi();
      yumi();
      chk("drain_empty", 160'(req_v_o), 160'd0);

      // ---------------- reset mid-stream while busy with 2 queued ----------------
      enq(mk(c_rd, c_sz64, 40'h00_8000_0040, c_cce));
      yumi();
      enq(mk(c_ucrd, c_sz8, 40'h00_8000_0050, c_cce));
      enq(mk(c_ucwr, c_sz8, 40'h00_8000_0060, c_cce));
      chk("pre_rst_full", 160'(lce_req_ready_o), 160'd0);
      reset_n_i = 1'b0;
      #1;
      chk("mid_rst_ready", 160'(lce_req_ready_o), 160'd0);
      chk("mid_rst_v", 160'(req_v_o), 160'd0);
      chk("mid_rst_errcnt", 160'(err_cnt_o), 160'd0);
      #3 reset_n_i = 1'b1;
      tick();
      chk("post_rst_ready", 160'(lce_req_ready_o), 160'd1);
      chk("post_rst_v", 160'(req_v_o), 160'd0);
      chk("post_rst_err", 160'(err_o), 160'd0);

      // ---------------- stats: 3 cached_rd, 2 amo ----------------
      for (int i = 1; i <= 3; i++) begin
         enq(mk(c_rd, c_sz64, 40'h00_8000_0000 + 40'(i * 64), c_cce));
         chk("stats_rd_v_idle", 160'(req_v_o), 160'd1);
         yumi();
         done();
      end
      for (int i = 0; i < 2; i++) begin
         enq(mk(c_amo, c_sz8, 40'h00_8000_0100 + 40'(i * 8), c_cce));
         chk("amo_v", 160'(req_v_o), 160'd1);
         chk("amo_class", 160'(req_class_o), 160'd4);
         yumi();
      end
`ifdef BP_CCE_REQ_INGRESS_STATS_EN
      chk("stats_on", stats_o, {32'd2, 32'd0, 32'd0, 32'd0, 32'd3});
`else
      chk("stats_off", stats_o, 160'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
